decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and operand width.
REQ-002 The block SHALL have parameter NREG, default 8, meaning the register count (address width 3).
REQ-003 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 The block SHALL have port enable_decode, input, 1: global decode enable.
REQ-006 The block SHALL have ports instr_valid (input, 1), instr (input, 32) and instr_ready (output, 1): the fetch handshake.
REQ-007 The block SHALL have ports wb_en (input, 1), wb_addr (input, 3) and wb_data (input, DATA_W): the writeback port.
REQ-008 The block SHALL have ports src1 and src2, output, DATA_W: the operands for Execute.
REQ-009 The block SHALL have port imm, output, 16: the immediate field.
REQ-010 The block SHALL have port control_in, output, 7: Execute control word, equal to instr[31:25].
REQ-011 The block SHALL have port dest_out, output, 3: destination register of the issued instruction.
REQ-012 The block SHALL have port enable_ex, output, 1: one-cycle issue strobe to Execute.
REQ-013 The block SHALL have port illegal_op, output, 1: one-cycle pulse flagging a dropped illegal opcode.

Function
REQ-014 The instruction fields SHALL be: opselect [31:29], operation [28:26], imm_sel [25], dest [24:22], rs1 [21:19], rs2 [18:16], imm [15:0].
REQ-015 The opselect encodings SHALL be: ARITH_LOGIC=000, SHIFT_REG=001, MEM_READ=010, MEM_WRITE=011; opselect values 1xx are illegal.
REQ-016 An instruction SHALL use rs2 when imm_sel=0 or opselect=MEM_WRITE (store data in rs2).
REQ-017 An instruction SHALL write dest unless it is MEM_WRITE or illegal.
REQ-018 Register 0 SHALL read as zero, ignore writes and never be busy.
REQ-019 The scoreboard SHALL hold one busy bit per register, set on issue of a writing instruction and cleared when wb_en=1 with a matching wb_addr.
REQ-020 A hazard SHALL exist if rs1 is busy, or rs2 is used and busy, or the instruction writes dest and dest is busy (WAW).
REQ-021 instr_ready SHALL equal enable_decode & ~reset & ~hazard(instr).
REQ-022 An instruction SHALL be accepted when instr_valid & instr_ready at edge N.
REQ-023 For an accepted legal instruction in cycle N, src1, src2, imm, control_in, dest_out and enable_ex=1 SHALL be registered so they are valid in cycle N+1.
REQ-024 enable_ex SHALL be 0 in every cycle without an issue.
REQ-025 Operand outputs SHALL hold their last value when no instruction issues.
REQ-026 An accepted illegal instruction SHALL be consumed without issue and SHALL pulse illegal_op in cycle N+1.
REQ-027 When a writeback clears a register's busy bit and an issue sets it in the same cycle, set SHALL win.
REQ-028 The writeback SHALL update the register file at the same edge it clears the busy bit.
REQ-029 When enable_decode=0, the block SHALL accept nothing and SHALL keep the scoreboard updating from writeback.

Reset
REQ-030 When reset=1 at a clock edge, the block SHALL clear all registers and busy bits to 0.
REQ-031 While reset=1, src1, src2, imm, control_in, dest_out, enable_ex, illegal_op and instr_ready SHALL be 0.
REQ-032 While reset=1, writeback SHALL be ignored.
REQ-033 A reset asserted mid-stall SHALL leave no instruction in flight once it deasserts.

Configuration
REQ-034 The macro DECODE_BYPASS_EN SHALL control same-cycle writeback bypass.
REQ-035 With DECODE_BYPASS_EN defined, a busy register matching an active wb_addr SHALL count as not busy, and its operand SHALL take wb_data in the same cycle.
REQ-036 Without DECODE_BYPASS_EN, the raw busy bit SHALL apply, so an instruction waiting on a writeback issues one cycle after it.

Structure
REQ-037 The package decode_pkg SHALL hold the opselect enum, the field-position localparams, the instruction struct typedef and the control word width.
REQ-038 The register file with zero-register handling SHALL be the sub-module regfile (2 combinational read ports, 1 synchronous write port).
REQ-039 The scoreboard SHALL reside in decode_issue.

Verification
REQ-040 A bench SHALL drive reset, then wb r3=0x0000_00AA, then ADD r1<-r3+r3 (imm_sel=0), and SHALL see enable_ex=1 one cycle after accept with src1=src2=0xAA, dest_out=1 and control_in=instr[31:25].
REQ-041 A bench SHALL issue r2<-r1 op, then r4<-r2 op back-to-back, with wb r2=0x5 three cycles later, and SHALL see instr_ready=0 until the writeback, then issue the same cycle (bypass on) or the next cycle (bypass off) with src1=0x5.
REQ-042 A bench SHALL issue two writers to r5 with no writeback and SHALL see the second stalled (WAW) until wb_addr=5.
REQ-043 A bench SHALL drive an instruction with opselect=3'b110 and SHALL see illegal_op pulse for 1 cycle, enable_ex=0 and the busy bits unchanged.
REQ-044 A bench SHALL issue MEM_WRITE rs2=r6 with imm=0x8000 and SHALL see imm=0x8000, src2=r6, and r0/dest not marked busy.
REQ-045 A bench SHALL assert reset during a stall with r2 busy and SHALL see all outputs 0, then after release r2 not busy and a dependent instruction issuing immediately with src1=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: opselect encodings, instruction field layout and widths.
// Used by decode_issue (build option DECODE_BYPASS_EN) and its regfile.
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int CTRL_W  = 7;
    localparam int REG_AW  = 3;
    localparam int IMM_W   = 16;

    localparam int OPSEL_LSB  = 29;
    localparam int OPER_LSB   = 26;
    localparam int IMMSEL_BIT = 25;
    localparam int DEST_LSB   = 22;
    localparam int RS1_LSB    = 19;
    localparam int RS2_LSB    = 16;
    localparam int IMM_LSB    = 0;

    typedef enum logic [2:0] {
        OP_ARITH_LOGIC = 3'b000,
        OP_SHIFT_REG   = 3'b001,
        OP_MEM_READ    = 3'b010,
        OP_MEM_WRITE   = 3'b011
    } opsel_e;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        opsel_e             opselect;
        logic [2:0]         operation;
        logic               imm_sel;
        logic [REG_AW-1:0]  dest;
        logic [REG_AW-1:0]  rs1;
        logic [REG_AW-1:0]  rs2;
        logic [IMM_W-1:0]   imm;
    } instr_t;

    function automatic logic isLegal(input logic [2:0] opsel);
        return ~opsel[2];
    endfunction

endpackage

// File: rtl/decode_issue_regfile.sv
// Register file with r0 hard-wired to zero: two combinational reads, one synchronous write.
module regfile
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [NREG];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage with a busy-bit scoreboard guarding RAW and WAW hazards.
// Define DECODE_BYPASS_EN to let a same-cycle writeback satisfy a waiting instruction.
module decode_issue
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_decode,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  src1,
    output logic [DATA_W-1:0]  src2,
    output logic [IMM_W-1:0]   imm,
    output logic [CTRL_W-1:0]  control_in,
    output logic [REG_AW-1:0]  dest_out,
    output logic               enable_ex,
    output logic               illegal_op
);

    instr_t            dec;
    logic              legal, isStore, usesRs2, writesDest;
    logic              wbActive, hazard, accept, issue;
    logic [NREG-1:0]   busy_q, busy_d, busyEff;
    logic [DATA_W-1:0] rdata1, rdata2, operand1, operand2;
    logic [DATA_W-1:0] src1_q, src2_q;
    logic [IMM_W-1:0]  imm_q;
    logic [CTRL_W-1:0] control_q;
    logic [REG_AW-1:0] dest_q;
    logic              enableEx_q, illegalOp_q;

    assign dec        = instr;
    assign legal      = isLegal(dec.opselect);
    assign isStore    = (dec.opselect == OP_MEM_WRITE);
    assign usesRs2    = ~dec.imm_sel | isStore;
    assign writesDest = legal & ~isStore & (dec.dest != '0);
    assign wbActive   = wb_en & ~reset;

    regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
        .clk_i    (clock),
        .rst_i    (reset),
        .we_i     (wbActive),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data),
        .raddr1_i (dec.rs1),
        .raddr2_i (dec.rs2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // With bypass, a register being written back this cycle is treated as ready
    // and its operand is taken straight from the writeback bus.
    always_comb begin
        busyEff  = busy_q;
        operand1 = rdata1;
        operand2 = rdata2;
`ifdef DECODE_BYPASS_EN
        if (wbActive) begin
            busyEff[wb_addr] = 1'b0;
            if ((wb_addr != '0) && (wb_addr == dec.rs1)) operand1 = wb_data;
            if ((wb_addr != '0) && (wb_addr == dec.rs2)) operand2 = wb_data;
        end
`endif
    end

    assign hazard      = busyEff[dec.rs1] | (usesRs2 & busyEff[dec.rs2])
                       | (writesDest & busyEff[dec.dest]);
    assign instr_ready = enable_decode & ~reset & ~hazard;
    assign accept      = instr_valid & instr_ready;
    assign issue       = accept & legal;

    // Set after clear so an issue claiming the register being written back wins.
    always_comb begin
        busy_d = busy_q;
        if (wbActive) busy_d[wb_addr] = 1'b0;
        if (issue && writesDest) busy_d[dec.dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            control_q   <= '0;
            dest_q      <= '0;
            enableEx_q  <= 1'b0;
            illegalOp_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            enableEx_q  <= issue;
            illegalOp_q <= accept & ~legal;
            if (issue) begin
                src1_q    <= operand1;
                src2_q    <= operand2;
                imm_q     <= dec.imm;
                control_q <= {dec.opselect, dec.operation, dec.imm_sel};
                dest_q    <= dec.dest;
            end
        end
    end

    // Outputs read zero for the whole reset window, not just after the first edge.
    assign src1       = reset ? '0 : src1_q;
    assign src2       = reset ? '0 : src2_q;
    assign imm        = reset ? '0 : imm_q;
    assign control_in = reset ? '0 : control_q;
    assign dest_out   = reset ? '0 : dest_q;
    assign enable_ex  = ~reset & enableEx_q;
    assign illegal_op = ~reset & illegalOp_q;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue; expected stall lengths follow DECODE_BYPASS_EN.
module tb_decode_issue;

`ifdef DECODE_BYPASS_EN
    localparam int WB_LAT = 0;
`else
    localparam int WB_LAT = 1;
`endif

    logic        clock, reset, enableDecode, instrValid, instrReady;
    logic [31:0] instrWord;
    logic        wbEn;
    logic [2:0]  wbAddr;
    logic [31:0] wbData;
    logic [31:0] src1, src2;
    logic [15:0] immOut;
    logic [6:0]  controlIn;
    logic [2:0]  destOut;
    logic        enableEx, illegalOp;

    typedef struct {
        int          tag;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [15:0] imm;
        logic [6:0]  ctrl;
        logic [2:0]  dest;
    } expIssue_t;

    expIssue_t issueQ[$];
    int        illegalQ[$];
    expIssue_t monItem;
    int        monTag;
    int        checks = 0;
    int        errors = 0;
    int        cycle  = 0;

    decode_issue #(.DATA_W(32), .NREG(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_decode (enableDecode),
        .instr_valid   (instrValid),
        .instr         (instrWord),
        .instr_ready   (instrReady),
        .wb_en         (wbEn),
        .wb_addr       (wbAddr),
        .wb_data       (wbData),
        .src1          (src1),
        .src2          (src2),
        .imm           (immOut),
        .control_in    (controlIn),
        .dest_out      (destOut),
        .enable_ex     (enableEx),
        .illegal_op    (illegalOp)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] os, input logic [2:0] op, input logic isel,
                                       input logic [2:0] d, input logic [2:0] r1, input logic [2:0] r2,
                                       input logic [15:0] im);
        return {os, op, isel, d, r1, r2, im};
    endfunction

    task automatic writeback(input logic [2:0] addr, input logic [31:0] data);
        wbEn   = 1'b1;
        wbAddr = addr;
        wbData = data;
        tick();
        wbEn   = 1'b0;
    endtask

    // Presents one instruction, measures its stall and queues the expected response.
    task automatic applyStimulus(input string name, input logic [31:0] word, input int expWait,
                                 input logic [31:0] e1, input logic [31:0] e2);
        int        waited;
        expIssue_t e;
        waited     = 0;
        instrWord  = word;
        instrValid = 1'b1;
        @(negedge clock);
        while (instrReady !== 1'b1 && waited < 40) begin
            waited++;
            @(negedge clock);
        end
        if (instrReady !== 1'b1) begin
            checkOutput({name, "_timeout"}, 64'd0, 64'd1);
            instrValid = 1'b0;
            return;
        end
        checkOutput({name, "_stall"}, 64'(waited), 64'(expWait));
        if (word[31]) begin
            illegalQ.push_back(cycle + 1);
        end else begin
            e.tag  = cycle + 1;
            e.s1   = e1;
            e.s2   = e2;
            e.imm  = word[15:0];
            e.ctrl = word[31:25];
            e.dest = word[24:22];
            issueQ.push_back(e);
        end
        tick();
        instrValid = 1'b0;
    endtask

    // Monitor: every issue or illegal pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (enableEx === 1'b1) begin
            if (issueQ.size() == 0) begin
                checkOutput("unexpectedIssue", 64'd1, 64'd0);
            end else begin
                monItem = issueQ.pop_front();
                checkOutput("issueCycle", 64'(cycle), 64'(monItem.tag));
                checkOutput("src1", 64'(src1), 64'(monItem.s1));
                checkOutput("src2", 64'(src2), 64'(monItem.s2));
                checkOutput("imm", 64'(immOut), 64'(monItem.imm));
                checkOutput("controlIn", 64'(controlIn), 64'(monItem.ctrl));
                checkOutput("destOut", 64'(destOut), 64'(monItem.dest));
            end
        end
        if (illegalOp === 1'b1) begin
            if (illegalQ.size() == 0) begin
                checkOutput("unexpectedIllegal", 64'd1, 64'd0);
            end else begin
                monTag = illegalQ.pop_front();
                checkOutput("illegalCycle", 64'(cycle), 64'(monTag));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        enableDecode = 1'b1;
        instrValid   = 1'b1;
        instrWord    = mk(3'd0, 3'd0, 1'b0, 3'd1, 3'd3, 3'd3, 16'h1234);
        wbEn         = 1'b0;
        wbAddr       = 3'd0;
        wbData       = 32'd0;
        tick();
        tick();
        @(negedge clock);
        checkOutput("resetReady", 64'(instrReady), 64'd0);
        checkOutput("resetEnableEx", 64'(enableEx), 64'd0);
        checkOutput("resetSrc1", 64'(src1), 64'd0);
        checkOutput("resetIllegal", 64'(illegalOp), 64'd0);
        tick();
        reset      = 1'b0;
        instrValid = 1'b0;

        // Basic issue with both operands from a written register.
        writeback(3'd3, 32'h0000_00AA);
        applyStimulus("add", mk(3'd0, 3'd0, 1'b0, 3'd1, 3'd3, 3'd3, 16'h1234), 0, 32'hAA, 32'hAA);
        writeback(3'd1, 32'h11);

        // RAW: second instruction waits for r2's writeback.
        applyStimulus("raw1", mk(3'd0, 3'd1, 1'b1, 3'd2, 3'd1, 3'd0, 16'h0010), 0, 32'h11, 32'h0);
        fork
            applyStimulus("raw2", mk(3'd1, 3'd2, 1'b1, 3'd4, 3'd2, 3'd0, 16'h0020), 2 + WB_LAT, 32'h5, 32'h0);
            begin tick(); tick(); writeback(3'd2, 32'h5); end
        join

        // WAW on r5, then a reader proving the second writer re-marked r5 busy.
        applyStimulus("waw1", mk(3'd0, 3'd0, 1'b1, 3'd5, 3'd3, 3'd0, 16'h0030), 0, 32'hAA, 32'h0);
        fork
            applyStimulus("waw2", mk(3'd0, 3'd3, 1'b1, 3'd5, 3'd0, 3'd0, 16'h0040), 3 + WB_LAT, 32'h0, 32'h0);
            begin repeat (3) tick(); writeback(3'd5, 32'h77); end
        join
        fork
            applyStimulus("setWins", mk(3'd2, 3'd0, 1'b1, 3'd0, 3'd5, 3'd0, 16'h0050), 2 + WB_LAT, 32'h99, 32'h0);
            begin tick(); tick(); writeback(3'd5, 32'h99); end
        join

        // Illegal opcode: dropped, pulses illegal_op, leaves r7 free.
        applyStimulus("illegal", mk(3'b110, 3'd0, 1'b0, 3'd7, 3'd0, 3'd0, 16'h0060), 0, 32'h0, 32'h0);
        applyStimulus("r7Free", mk(3'd0, 3'd0, 1'b1, 3'd0, 3'd7, 3'd0, 16'h0000), 0, 32'h0, 32'h0);

        // Store reads rs2 and marks nothing busy.
        writeback(3'd6, 32'h66);
        applyStimulus("store", mk(3'd3, 3'd0, 1'b1, 3'd2, 3'd3, 3'd6, 16'h8000), 0, 32'hAA, 32'h66);
        applyStimulus("storeNoBusy", mk(3'd0, 3'd0, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0070), 0, 32'h5, 32'h0);
        applyStimulus("r0Free", mk(3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0080), 0, 32'h0, 32'h0);

        // Decode disabled: nothing accepted but writeback still clears r4.
        enableDecode = 1'b0;
        instrWord    = mk(3'd0, 3'd0, 1'b1, 3'd0, 3'd4, 3'd0, 16'h0090);
        instrValid   = 1'b1;
        wbEn         = 1'b1;
        wbAddr       = 3'd4;
        wbData       = 32'h44;
        @(negedge clock);
        checkOutput("disabledReady", 64'(instrReady), 64'd0);
        tick();
        wbEn = 1'b0;
        @(negedge clock);
        checkOutput("disabledReady2", 64'(instrReady), 64'd0);
        tick();
        enableDecode = 1'b1;
        instrValid   = 1'b0;
        applyStimulus("r4Cleared", mk(3'd0, 3'd0, 1'b1, 3'd0, 3'd4, 3'd0, 16'h0090), 0, 32'h44, 32'h0);

        // Reset in the middle of a stall on r2.
        applyStimulus("r2Writer", mk(3'd0, 3'd0, 1'b1, 3'd2, 3'd0, 3'd0, 16'h00F0), 0, 32'h0, 32'h0);
        instrWord  = mk(3'd0, 3'd1, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0100);
        instrValid = 1'b1;
        @(negedge clock);
        checkOutput("stallBeforeReset", 64'(instrReady), 64'd0);
        tick();
        reset  = 1'b1;
        wbEn   = 1'b1;
        wbAddr = 3'd3;
        wbData = 32'hBB;
        @(negedge clock);
        checkOutput("rstSrc1", 64'(src1), 64'd0);
        checkOutput("rstSrc2", 64'(src2), 64'd0);
        checkOutput("rstImm", 64'(immOut), 64'd0);
        checkOutput("rstControl", 64'(controlIn), 64'd0);
        checkOutput("rstDest", 64'(destOut), 64'd0);
        checkOutput("rstEnableEx", 64'(enableEx), 64'd0);
        checkOutput("rstIllegal", 64'(illegalOp), 64'd0);
        checkOutput("rstReady", 64'(instrReady), 64'd0);
        tick();
        wbEn = 1'b0;
        tick();
        reset = 1'b0;
        applyStimulus("afterReset", mk(3'd0, 3'd1, 1'b1, 3'd0, 3'd2, 3'd0, 16'h0100), 0, 32'h0, 32'h0);
        applyStimulus("wbIgnored", mk(3'd0, 3'd0, 1'b1, 3'd0, 3'd3, 3'd0, 16'h0110), 0, 32'h0, 32'h0);

        repeat (3) tick();
        checkOutput("pendingIssues", 64'(issueQ.size()), 64'd0);
        checkOutput("pendingIllegal", 64'(illegalQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
